// File: rtl/enemy_action_gen_pkg.sv
// Shared types and LFSR helpers for the enemy
// action generator.
package enemy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    CHECK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_LFSR   = 2'd0,
    MODE_LEGACY = 2'd1,
    MODE_MIXED  = 2'd2
  } mode_t;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

  // Tap mask, bit n-1 set for tap n.
  function automatic logic [31:0] lfsr_taps(
    input int width
  );
    logic [31:0] t;
    unique case (width)
      8:       t = 32'h0000_00B8;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_B400;
    endcase
    return t;
  endfunction

  // One Fibonacci shift-left step.
  function automatic logic [31:0] lfsr_next(
    input logic [31:0] q,
    input int          width
  );
    logic [31:0] msk;
    logic        fb;
    if (width >= 32) msk = '1;
    else msk = (32'd1 << width) - 32'd1;
    fb = ^(q & lfsr_taps(width));
    return ((q << 1) | {31'd0, fb}) & msk;
  endfunction

endpackage

// File: rtl/enemy_action_gen_if.sv
// Request/result bundle between game state
// and the enemy action generator.
interface enemy_action_gen_if #(
  parameter int LFSR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_ACTIONS = 3
);
  localparam int ACT_W =
    (NUM_ACTIONS > 2) ? $clog2(NUM_ACTIONS) : 1;

  logic                   trigger;
  logic [1:0]             mode;
  logic [DATA_W-1:0]      ammo;
  logic [DATA_W-1:0]      tm;
  logic [NUM_ACTIONS-1:0] action_mask;
  logic                   seed_load;
  logic [LFSR_W-1:0]      seed_in;
  logic                   busy;
  logic                   valid;
  logic [ACT_W-1:0]       action;
  logic                   fallback;

  modport master (
    output trigger, mode, ammo, tm,
    output action_mask, seed_load, seed_in,
    input  busy, valid, action, fallback
  );

  modport slave (
    input  trigger, mode, ammo, tm,
    input  action_mask, seed_load, seed_in,
    output busy, valid, action, fallback
  );

endinterface

// File: rtl/enemy_action_gen_lfsr.sv
// Seedable Fibonacci LFSR; a zero load value
// is replaced by SEED so the state never locks.
module lfsr_core
  import enemy_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = W'(DEFAULT_SEED)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Load wins over step; hold otherwise.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      q_d = W'(lfsr_next(32'(q_q), W));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) q_q <= SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/enemy_action_gen.sv
// Enemy action picker: LFSR / mixed draws with
// mask rejection, plus deterministic legacy mode.
module enemy_action_gen
  import enemy_pkg::*;
#(
  parameter int LFSR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_ACTIONS = 3,
  parameter int MAX_TRIES   = 8,
  parameter logic [LFSR_W-1:0] SEED =
    LFSR_W'(DEFAULT_SEED)
) (
  input logic               clk,
  input logic               reset,
  enemy_action_gen_if.slave bus
);

  localparam int ACT_W =
    (NUM_ACTIONS > 2) ? $clog2(NUM_ACTIONS) : 1;
  localparam int CAND_W = ACT_W;
  localparam int MSK_W  = 1 << ACT_W;
  localparam int XW =
    (LFSR_W > DATA_W) ? LFSR_W : DATA_W;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_t                 state_q, state_d;
  mode_t                  mode_q, mode_d;
  mode_t                  mode_in;
  logic [DATA_W-1:0]      ammo_q, ammo_d;
  logic [DATA_W-1:0]      tm_q, tm_d;
  logic [NUM_ACTIONS-1:0] mask_q, mask_d;
  logic [TRY_W-1:0]       tries_q, tries_d;
  logic [CAND_W-1:0]      cand_q, cand_d;
  logic [ACT_W-1:0]       action_q, action_d;
  logic                   fallback_q, fallback_d;

  logic              lfsr_step;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_nx;

  logic [XW-1:0]     mix;
  logic [DATA_W:0]   leg_sum;
  logic [DATA_W:0]   leg_mod;
  logic [CAND_W-1:0] draw_cand;
  logic [MSK_W-1:0]  mask_ext;
  logic              cand_ok;
  logic [ACT_W-1:0]  low_idx;

  lfsr_core #(
    .W    (LFSR_W),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (bus.seed_in),
    .q        (lfsr_q)
  );

  // Reserved mode code folds onto plain LFSR.
  always_comb begin
    mode_in = MODE_LFSR;
    unique case (1'b1)
      (bus.mode == 2'd1): mode_in = MODE_LEGACY;
      (bus.mode == 2'd2): mode_in = MODE_MIXED;
      default:            mode_in = MODE_LFSR;
    endcase
  end

  // Candidate from the post-step LFSR value
  // or the legacy arithmetic.
  always_comb begin
    lfsr_nx =
      LFSR_W'(lfsr_next(32'(lfsr_q), LFSR_W));
    mix = XW'(lfsr_nx) ^ XW'(ammo_q)
        ^ XW'(tm_q);
    leg_sum = {1'b0, ammo_q >> 1}
            + {1'b0, tm_q / DATA_W'(3)};
    leg_mod = leg_sum % (DATA_W+1)'(NUM_ACTIONS);
    unique case (1'b1)
      (mode_q == MODE_LEGACY):
        draw_cand = CAND_W'(leg_mod);
      (mode_q == MODE_MIXED):
        draw_cand = mix[CAND_W-1:0];
      default:
        draw_cand = lfsr_nx[CAND_W-1:0];
    endcase
  end

  // Range and mask check; out-of-range indices
  // see the zero padding of mask_ext.
  always_comb begin
    mask_ext = MSK_W'(mask_q);
    cand_ok  =
      ({1'b0, cand_q} < (CAND_W+1)'(NUM_ACTIONS))
      && mask_ext[cand_q];
  end

  // Lowest set mask bit, 0 when mask is empty.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ACTIONS - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = ACT_W'(i);
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    ammo_d     = ammo_q;
    tm_d       = tm_q;
    mask_d     = mask_q;
    tries_d    = tries_q;
    cand_d     = cand_q;
    action_d   = action_q;
    fallback_d = fallback_q;
    lfsr_step  = 1'b0;
    lfsr_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.seed_load) begin
          lfsr_load = 1'b1;
        end else if (bus.trigger) begin
          mode_d  = mode_in;
          ammo_d  = bus.ammo;
          tm_d    = bus.tm;
          mask_d  = bus.action_mask;
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        lfsr_step = (mode_q != MODE_LEGACY);
        cand_d    = draw_cand;
        tries_d   = tries_q + TRY_W'(1);
        state_d   = CHECK;
      end
      CHECK: begin
        if (cand_ok) begin
          action_d   = cand_q;
          fallback_d = 1'b0;
          state_d    = DONE;
        end else if (
          tries_q < TRY_W'(MAX_TRIES)
          && mode_q != MODE_LEGACY
        ) begin
          state_d = DRAW;
        end else begin
          action_d   = low_idx;
          fallback_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_LFSR;
      ammo_q     <= '0;
      tm_q       <= '0;
      mask_q     <= '0;
      tries_q    <= '0;
      cand_q     <= '0;
      action_q   <= '0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      ammo_q     <= ammo_d;
      tm_q       <= tm_d;
      mask_q     <= mask_d;
      tries_q    <= tries_d;
      cand_q     <= cand_d;
      action_q   <= action_d;
      fallback_q <= fallback_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.valid    = (state_q == DONE);
  assign bus.action   = action_q;
  assign bus.fallback = fallback_q;

endmodule

// File: tb/tb_enemy_action_gen.sv
// Scoreboard bench for enemy_action_gen:
// directed legacy vectors plus LFSR golden model.
module tb_enemy_action_gen;
  import enemy_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  enemy_action_gen_if #(
    .LFSR_W      (16),
    .DATA_W      (8),
    .NUM_ACTIONS (3)
  ) bus ();

  enemy_action_gen #(
    .LFSR_W      (16),
    .DATA_W      (8),
    .NUM_ACTIONS (3),
    .MAX_TRIES   (8),
    .SEED        (16'hACE1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] act;
    logic       fb;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] m_lfsr;
  bit          hist_en = 0;
  int          hist[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string name,
    input int    act,
    input int    req
  );
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, req);
    end
  endtask

  // Monitor: pop and compare on every valid.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && bus.valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("action", int'(bus.action), int'(e.act));
        chk("fallback", int'(bus.fallback),
            int'(e.fb));
        chk("latency", cyc, e.cyc);
        if (hist_en) hist[bus.action]++;
      end
    end
  end

  function automatic void model(
    input  logic [1:0] md,
    input  logic [7:0] am,
    input  logic [7:0] tmv,
    input  logic [2:0] mk,
    output logic [1:0] act,
    output logic       fb,
    output int         draws
  );
    logic [8:0] s;
    logic [1:0] c;
    bit         ok;
    ok = 0;
    draws = 0;
    c = 2'd0;
    if (md == 2'd1) begin
      s = {1'b0, am >> 1} + {1'b0, tmv / 8'd3};
      c = 2'(s % 9'd3);
      draws = 1;
      ok = mk[c];
    end else begin
      for (int t = 0; t < 8 && !ok; t++) begin
        m_lfsr = {m_lfsr[14:0],
                  m_lfsr[15] ^ m_lfsr[13]
                  ^ m_lfsr[12] ^ m_lfsr[10]};
        if (md == 2'd2)
          c = m_lfsr[1:0] ^ am[1:0] ^ tmv[1:0];
        else
          c = m_lfsr[1:0];
        draws++;
        ok = (c != 2'd3) && mk[c];
      end
    end
    if (ok) begin
      act = c;
      fb = 1'b0;
    end else begin
      fb = 1'b1;
      act = mk[0] ? 2'd0 : mk[1] ? 2'd1 :
            mk[2] ? 2'd2 : 2'd0;
    end
  endfunction

  task automatic req(
    input logic [1:0] md,
    input logic [7:0] am,
    input logic [7:0] tmv,
    input logic [2:0] mk,
    input bit         extra,
    input bit         hand,
    input logic [1:0] hact,
    input logic       hfb
  );
    exp_t e;
    int   draws;
    int   c;
    @(negedge clk);
    bus.mode = md;
    bus.ammo = am;
    bus.tm = tmv;
    bus.action_mask = mk;
    bus.trigger = 1'b1;
    c = cyc;
    if (hand) begin
      e.act = hact;
      e.fb = hfb;
      draws = 1;
    end else begin
      model(md, am, tmv, mk, e.act, e.fb, draws);
    end
    e.cyc = c + 1 + 2 * draws;
    sb.push_back(e);
    for (int k = 1; k <= e.cyc - c; k++) begin
      @(negedge clk);
      bus.trigger = extra && (k <= 2);
      if (k == 1) begin
        bus.mode = ~md;
        bus.ammo = ~am;
        bus.tm = ~tmv;
        bus.action_mask = ~mk;
      end
      chk("busy", int'(bus.busy), 1);
    end
    @(negedge clk);
    bus.trigger = 1'b0;
    chk("busy_end", int'(bus.busy), 0);
    chk("valid_seen", sb.size(), 0);
    sb.delete();
  endtask

  task automatic seed(
    input logic [15:0] v,
    input bit          trg
  );
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed_in = v;
    bus.trigger = trg;
    bus.mode = 2'd0;
    bus.action_mask = 3'b111;
    m_lfsr = (v == 16'd0) ? 16'hACE1 : v;
    @(negedge clk);
    bus.seed_load = 1'b0;
    bus.trigger = 1'b0;
    repeat (2) begin
      chk("seed_idle_busy", int'(bus.busy), 0);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] am;
    logic [7:0] tmv;
    logic [2:0] mk;
    logic [1:0] act;
    logic       fb;
  } leg_t;

  leg_t leg[8];

  initial begin
    leg[0] = '{8'd10,  8'd9,   3'b111, 2'd2, 1'b0};
    leg[1] = '{8'd10,  8'd9,   3'b011, 2'd0, 1'b1};
    leg[2] = '{8'd10,  8'd9,   3'b000, 2'd0, 1'b1};
    leg[3] = '{8'd10,  8'd9,   3'b110, 2'd2, 1'b0};
    leg[4] = '{8'd0,   8'd0,   3'b111, 2'd0, 1'b0};
    leg[5] = '{8'd255, 8'd255, 3'b111, 2'd2, 1'b0};
    leg[6] = '{8'd7,   8'd4,   3'b010, 2'd1, 1'b0};
    leg[7] = '{8'd7,   8'd4,   3'b100, 2'd2, 1'b1};
  end

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.trigger = 1'b0;
    bus.mode = 2'd0;
    bus.ammo = 8'd0;
    bus.tm = 8'd0;
    bus.action_mask = 3'b000;
    bus.seed_load = 1'b0;
    bus.seed_in = 16'd0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    m_lfsr = 16'hACE1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_action", int'(bus.action), 0);
    chk("rst_fallback", int'(bus.fallback), 0);
    chk("rst_lfsr", int'(u_dut.u_lfsr.q),
        32'hACE1);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      req(2'd1, leg[i].am, leg[i].tmv, leg[i].mk,
          0, 1, leg[i].act, leg[i].fb);

    req(2'd1, 8'd10, 8'd9, 3'b111, 1, 1,
        2'd2, 1'b0);
    repeat (4) @(negedge clk);

    req(2'd2, 8'h5A, 8'h33, 3'b111, 0, 0, 0, 0);
    req(2'd2, 8'h01, 8'h02, 3'b010, 0, 0, 0, 0);
    req(2'd3, 8'h00, 8'h00, 3'b101, 0, 0, 0, 0);
    req(2'd0, 8'h00, 8'h00, 3'b100, 0, 0, 0, 0);
    req(2'd0, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0);

    hist_en = 1;
    repeat (1000)
      req(2'd0, 8'd0, 8'd0, 3'b101, 0, 0, 0, 0);
    hist_en = 0;
    chk("act1_never", hist[1], 0);
    chk("act0_count",
        int'(hist[0] >= 440 && hist[0] <= 560), 1);
    chk("act2_count",
        int'(hist[2] >= 440 && hist[2] <= 560), 1);

    seed(16'h1234, 0);
    repeat (20)
      req(2'd0, 8'd0, 8'd0, 3'b110, 0, 0, 0, 0);
    seed(16'h1234, 0);
    repeat (20)
      req(2'd0, 8'd0, 8'd0, 3'b110, 0, 0, 0, 0);
    seed(16'h0000, 0);
    repeat (20)
      req(2'd0, 8'd0, 8'd0, 3'b110, 0, 0, 0, 0);

    seed(16'h00FF, 1);
    req(2'd0, 8'd0, 8'd0, 3'b011, 0, 0, 0, 0);

    req(2'd1, 8'd10, 8'd9, 3'b111, 0, 1,
        2'd2, 1'b0);
    @(negedge clk);
    bus.mode = 2'd1;
    bus.ammo = 8'd10;
    bus.tm = 8'd9;
    bus.action_mask = 3'b111;
    bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    @(negedge clk);
    chk("in_check", int'(u_dut.state_q),
        int'(CHECK));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", int'(u_dut.state_q),
        int'(IDLE));
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_valid", int'(bus.valid), 0);
    chk("abort_action", int'(bus.action), 0);
    chk("abort_fallback", int'(bus.fallback), 0);
    chk("abort_lfsr", int'(u_dut.u_lfsr.q),
        32'hACE1);
    reset = 1'b0;
    m_lfsr = 16'hACE1;
    repeat (4) @(negedge clk);
    req(2'd0, 8'd0, 8'd0, 3'b101, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_action_gen.md
# enemy_action_gen

Parametrised successor to the enemy decision logic in the game subsystem. Picks one of `NUM_ACTIONS` enemy actions per request using a seedable Fibonacci LFSR. Draws are unbiased, made by rejection sampling against a per-request action mask. A legacy arithmetic mode is also available. Sits between the game-state registers (ammo, turn counter) and the enemy behaviour logic, with a request/valid handshake in the single system clock domain.

## Interface
- `LFSR_W`, 16: LFSR width; supported values 8, 16, 32.
- `DATA_W`, 8: width of `ammo` and `tm`.
- `NUM_ACTIONS`, 3: number of actions; 2..16.
- `MAX_TRIES`, 8: maximum rejection-sampling draws before fallback.
- `SEED`, 16'hACE1: reset and substitute seed; must be non-zero.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `trigger` in 1: one-cycle decision request; sampled only in IDLE.
- `mode` in 2: 0 = LFSR, 1 = LEGACY, 2 = MIXED, 3 = reserved (behaves as 0). Latched on trigger.
- `ammo` in DATA_W: game state; latched on trigger.
- `tm` in DATA_W: turn/time counter; latched on trigger.
- `action_mask` in NUM_ACTIONS: bit i set means action i is allowed; latched on trigger.
- `seed_load` in 1: load `seed_in` into the LFSR; honoured only in IDLE.
- `seed_in` in LFSR_W: new seed; a value of 0 loads `SEED` instead.
- `busy` out 1: high from the cycle after an accepted trigger through the DONE cycle.
- `valid` out 1: one-cycle pulse; `action` is new this cycle.
- `action` out ACT_W: chosen action. ACT_W = max(1, $clog2(NUM_ACTIONS)). Held until the next `valid`.
- `fallback` out 1: qualifies `valid`; set when the result came from the fallback rule.

## Operation
- **States:** IDLE, DRAW, CHECK, DONE.
- **IDLE**
  - `seed_load` high: LFSR <= `seed_in` (or `SEED` if `seed_in` is 0). Any `trigger` in the same cycle is dropped.
  - Otherwise, `trigger` high: latch `mode`, `ammo`, `tm` and `action_mask`; clear the try counter; go to DRAW.
- **DRAW:** compute and register the candidate `cand` (CAND_W = ACT_W bits).
  - LFSR mode: step the LFSR once; `cand` = low CAND_W bits of the new LFSR state.
  - MIXED mode: step the LFSR once; `cand` = low CAND_W bits of (LFSR ^ ammo ^ tm). Operands are zero-extended to max(LFSR_W, DATA_W).
  - LEGACY mode: no LFSR step; `cand` = ((ammo >> 1) + tm / 3) % NUM_ACTIONS, computed in DATA_W+1 bits.
  - Increment the try counter.
- **CHECK**
  - Accept if `cand` < NUM_ACTIONS and `action_mask[cand]` = 1. On accept: `action` <= `cand`, `fallback` <= 0, go to DONE.
  - Reject with tries < MAX_TRIES and mode not LEGACY: go back to DRAW.
  - Otherwise apply the fallback rule: `action` <= index of the lowest set bit of `action_mask`, or 0 if the mask is all zero. Set `fallback` <= 1 and go to DONE.
  - LEGACY mode never retries; its result is deterministic.
- **DONE:** `valid` = 1 for this cycle; go to IDLE.
- **LFSR**
  - Fibonacci shift-left; feedback is the XOR of the tap bits.
  - Taps: 8 → 8,6,5,4; 16 → 16,14,13,11; 32 → 32,22,2,1.
  - The LFSR never holds 0.
  - It steps only in DRAW for the LFSR and MIXED modes, so sequences are reproducible from a seed.
- **Ignored inputs:** `trigger` and `seed_load` outside IDLE are ignored and not queued. Input changes after the latch cycle have no effect on the decision in progress.

## Timing
- **Reset values:** state IDLE, LFSR = `SEED`, `action` = 0, `valid` = 0, `busy` = 0, `fallback` = 0, try counter = 0.
- **Latency:** trigger in cycle T, accepted on the first draw → DRAW at T+1, CHECK at T+2, `valid` at T+3. Each rejection adds 2 cycles.
- **Worst case:** `valid` at T+1+2·MAX_TRIES.
- **LEGACY mode:** always T+3.
- **Back-to-back:** the earliest next accepted trigger is the cycle after DONE (T+4). `busy` is high from T+1 through T+3 inclusive.
- **Reset mid-operation:** reset in any state returns to IDLE next cycle with the reset values above. No `valid` is produced for the aborted request.

## Structure
- **Package `enemy_pkg`:**
  - `state_t` enum (IDLE, DRAW, CHECK, DONE);
  - `mode_t` enum (MODE_LFSR, MODE_LEGACY, MODE_MIXED);
  - function `lfsr_taps(width)` returning the tap mask;
  - default `SEED` constant.
- **Sub-module `lfsr_core`:**
  - parameters: `W`, `SEED`;
  - ports: `clk`, `reset`, `step`, `load`, `load_val`, `q`;
  - does the zero-seed substitution internally.
- **Top level:** FSM, candidate arithmetic, mask check and lowest-set-bit priority encoder.

## Test plan
1. Reset → `busy` = 0, `valid` = 0, `action` = 0, `fallback` = 0; internal LFSR = 16'hACE1.
2. LEGACY mode, `ammo` = 10, `tm` = 9, mask 3'b111, trigger at T → `valid` at T+3, `action` = 2, `fallback` = 0; `busy` high for T+1..T+3.
3. LEGACY mode, `ammo` = 10, `tm` = 9, mask 3'b011 → `action` = 0, `fallback` = 1 at T+3. Mask 3'b000 → `action` = 0, `fallback` = 1.
4. LFSR mode, mask 3'b101, 1000 triggers →
   - action 1 never appears;
   - every `action` and latency matches the bench's LFSR golden model;
   - actions 0 and 2 each occur 500±60 times.
5. `seed_load` with `seed_in` = 16'h1234, run 20 draws, reload 16'h1234, rerun → identical `action` sequence. `seed_in` = 0 → same sequence as after reset.
6. Control edge cases:
   - `trigger` at T+1 and T+2 → ignored, exactly one `valid`;
   - `seed_load` together with `trigger` in IDLE → no request starts;
   - reset asserted in CHECK → no `valid`; state IDLE and `busy` = 0 the next cycle.
